alarm_ctrl: RTL and testbench

Sequential controller for the car warning alarm: qualifies the raw warning condition (lights on, door open, ignition off), then drives a timed on/off chime pattern with a beep limit and a driver mute. It sits between the raw sensor inputs and the buzzer driver and replaces direct combinational drive of the alarm line.

---
 rtl/alarm_ctrl_if.sv | 17 +
 rtl/alarm_ctrl.sv | 84 ++++++++
 tb/tb_alarm_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: sensor inputs and buzzer outputs of the car warning alarm
//   sLuz, sPrta, sIgn : lights on, door open, ignition on
//   sMute             : driver mute request (level)
//   sAlarm            : buzzer drive
//   sSilenced         : muted or beep limit reached
//   sBeepCnt          : completed beeps in the current episode
interface alarm_ctrl_if;
  logic       sLuz;
  logic       sPrta;
  logic       sIgn;
  logic       sMute;
  logic       sAlarm;
  logic       sSilenced;
  logic [7:0] sBeepCnt;
  modport master (output sLuz, sPrta, sIgn, sMute, input sAlarm, sSilenced, sBeepCnt);
  modport slave  (input sLuz, sPrta, sIgn, sMute, output sAlarm, sSilenced, sBeepCnt);
endinterface

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: qualifies lights-on/door-open/ignition-off and drives a timed chime
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sensor inputs in, registered sAlarm/sSilenced/sBeepCnt out
module alarm_ctrl #(
  parameter int DEB_CYC   = 4,
  parameter int ON_CYC    = 3,
  parameter int OFF_CYC   = 2,
  parameter int MAX_BEEPS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  alarm_ctrl_if.slave  bus
);
  localparam int MAXP = (DEB_CYC > ON_CYC) ? ((DEB_CYC > OFF_CYC) ? DEB_CYC : OFF_CYC)
                                           : ((ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC);
  localparam int W = $clog2(MAXP + 1);
  typedef enum logic [2:0] {IDLE, QUAL, ON, OFF, SILENT} state_t;
  state_t         r_state, w_next;
  logic [W-1:0]   r_cnt, w_cnt;
  logic [7:0]     r_beeps, w_beeps, w_inc;
  logic           r_alarm, r_sil, w_cond;
  assign w_cond = bus.sLuz & bus.sPrta & ~bus.sIgn;
  // saturating increment so an unlimited chime never wraps the count
  assign w_inc  = (r_beeps == 8'hFF) ? r_beeps : r_beeps + 8'd1;
  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_beeps = r_beeps;
    if (r_state == IDLE) begin
      if (w_cond) begin
        w_next = (DEB_CYC == 1) ? ON : QUAL;
        w_cnt  = W'(1);
      end
    end else if (!w_cond) begin
      w_next  = IDLE;
      w_cnt   = '0;
      w_beeps = '0;
    end else if (bus.sMute && r_state != SILENT) begin
      w_next = SILENT;
      w_cnt  = '0;
    end else begin
      unique case (r_state)
        QUAL: begin
          // counter holds samples taken so far; this edge is one more
          w_next = (r_cnt == W'(DEB_CYC - 1)) ? ON : QUAL;
          w_cnt  = (r_cnt == W'(DEB_CYC - 1)) ? W'(1) : r_cnt + W'(1);
        end
        ON: begin
          if (r_cnt == W'(ON_CYC)) begin
            w_beeps = w_inc;
            w_next  = (MAX_BEEPS != 0 && w_inc == 8'(MAX_BEEPS)) ? SILENT : OFF;
            w_cnt   = (MAX_BEEPS != 0 && w_inc == 8'(MAX_BEEPS)) ? '0 : W'(1);
          end else begin
            w_cnt = r_cnt + W'(1);
          end
        end
        OFF: begin
          w_next = (r_cnt == W'(OFF_CYC)) ? ON : OFF;
          w_cnt  = (r_cnt == W'(OFF_CYC)) ? W'(1) : r_cnt + W'(1);
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_beeps <= '0;
      r_alarm <= 1'b0;
      r_sil   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_beeps <= w_beeps;
      r_alarm <= (w_next == ON);
      r_sil   <= (w_next == SILENT);
    end
  end
  assign bus.sAlarm    = r_alarm;
  assign bus.sSilenced = r_sil;
  assign bus.sBeepCnt  = r_beeps;
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: scoreboard bench for alarm_ctrl against a run-length chime model
module tb_alarm_ctrl;
  localparam int DEB = 4, ONC = 3, OFFC = 2, MAXB = 3, P = ONC + OFFC;
  typedef struct packed {logic a; logic s; logic [7:0] c;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int errors = 0, checks = 0;
  exp_t q[$];
  int m_run, m_frozen;
  bit m_muted;
  alarm_ctrl_if bus();
  alarm_ctrl #(.DEB_CYC(DEB), .ON_CYC(ONC), .OFF_CYC(OFFC), .MAX_BEEPS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // expected outputs from the number of consecutive qualifying samples
  function automatic exp_t model_out(input int run, input bit muted, input int frozen);
    exp_t e;
    int t, b, pos, c;
    e = '0;
    if (muted) begin
      e.s = 1'b1;
      e.c = 8'(frozen);
    end else if (run >= DEB) begin
      t = run - DEB;
      b = t / P;
      pos = t % P;
      c = b + ((pos >= ONC) ? 1 : 0);
      if (MAXB != 0 && c > MAXB) c = MAXB;
      if (c > 255) c = 255;
      e.s = (MAXB != 0 && c == MAXB);
      e.a = !e.s && pos < ONC;
      e.c = 8'(c);
    end
    return e;
  endfunction
  task automatic step(input bit luz, input bit prta, input bit ign, input bit mute);
    exp_t pre;
    bit cond;
    bus.sLuz = luz; bus.sPrta = prta; bus.sIgn = ign; bus.sMute = mute;
    cond = luz & prta & ~ign;
    pre = model_out(m_run, m_muted, m_frozen);
    if (!cond) begin
      m_run = 0;
      m_muted = 0;
    end else if (!m_muted) begin
      if (mute && m_run > 0 && !pre.s) begin
        m_muted = 1;
        m_frozen = int'(pre.c);
      end else begin
        m_run++;
      end
    end
    q.push_back(model_out(m_run, m_muted, m_frozen));
    @(negedge clk);
  endtask
  task automatic hold(input int n, input bit luz, input bit prta, input bit ign, input bit mute);
    for (int i = 0; i < n; i++) step(luz, prta, ign, mute);
  endtask
  task automatic m_reset;
    m_run = 0; m_muted = 0; m_frozen = 0;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        checks++;
        if ({bus.sAlarm, bus.sSilenced, bus.sBeepCnt} !== 10'd0) begin
          errors++;
          $display("FAIL reset_outputs t=%0t got a=%b s=%b c=%0d want all 0", $time,
                   bus.sAlarm, bus.sSilenced, bus.sBeepCnt);
        end
      end else if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.sAlarm !== e.a) begin
          errors++;
          $display("FAIL sAlarm t=%0t got %b want %b", $time, bus.sAlarm, e.a);
        end
        checks++;
        if (bus.sSilenced !== e.s) begin
          errors++;
          $display("FAIL sSilenced t=%0t got %b want %b", $time, bus.sSilenced, e.s);
        end
        checks++;
        if (bus.sBeepCnt !== e.c) begin
          errors++;
          $display("FAIL sBeepCnt t=%0t got %0d want %0d", $time, bus.sBeepCnt, e.c);
        end
      end
    end
  end
  initial begin : stimulus
    m_reset();
    bus.sLuz = 1'b1; bus.sPrta = 1'b1; bus.sIgn = 1'b0; bus.sMute = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(6, 1, 1, 0, 0);
    hold(1, 0, 1, 0, 0);
    hold(3, 1, 1, 0, 0);
    hold(1, 1, 1, 1, 0);
    hold(7, 1, 1, 0, 0);
    hold(1, 1, 0, 0, 0);
    hold(20, 1, 1, 0, 0);
    hold(2, 1, 0, 0, 0);
    hold(10, 1, 1, 0, 0);
    hold(1, 1, 1, 0, 1);
    hold(4, 1, 1, 0, 0);
    hold(1, 0, 0, 0, 0);
    hold(7, 1, 1, 0, 0);
    hold(1, 1, 1, 1, 0);
    hold(9, 1, 1, 0, 0);
    hold(1, 0, 1, 0, 0);
    hold(5, 1, 1, 0, 0);
    hold(1, 0, 1, 0, 1);
    hold(5, 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 19) != 0, $urandom_range(0, 19) != 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
